// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, op encodings and FSM state type for the EX mul/div unit

package muldiv_pkg;

   localparam int ITER  = 32;
   localparam int CNT_W = $clog2(ITER);

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam logic [ITER-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2
   } state_t;

   function automatic logic [ITER-1:0] cond_neg(input logic [ITER-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one iteration of shift-add multiply or restoring shift-subtract divide

module muldiv_step
   import muldiv_pkg::*;
(
   input  logic                is_div,
   input  logic [ITER-1:0]     mag,
   input  logic [2*ITER-1:0]   acc,
   input  logic [ITER-1:0]     mq,
   output logic [2*ITER-1:0]   acc_next,
   output logic [ITER-1:0]     mq_next
);

   logic [ITER:0]   sum;
   logic [ITER:0]   shifted;
   logic [ITER+1:0] diff;

   // Multiply: product bits enter at the top of acc and shift down; mq holds the multiplier.
   // Divide: acc[ITER:0] is the partial remainder; mq shifts dividend out and quotient in.
   always_comb begin
      sum      = {1'b0, acc[2*ITER-1:ITER]} + (mq[0] ? {1'b0, mag} : '0);
      shifted  = {acc[ITER-1:0], mq[ITER-1]};
      diff     = {1'b0, shifted} - {2'b00, mag};
      acc_next = {sum, acc[ITER-1:1]};
      mq_next  = {1'b0, mq[ITER-1:1]};
      if (is_div) begin
         if (!diff[ITER+1]) begin
            acc_next = {{(ITER-1){1'b0}}, diff[ITER:0]};
            mq_next  = {mq[ITER-2:0], 1'b1};
         end else begin
            acc_next = {{(ITER-1){1'b0}}, shifted};
            mq_next  = {mq[ITER-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO and stall
// Optional MULDIV_ZERO_SKIP_EN: zero multiply operand or zero divisor bypasses CALC.

module ex_muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [ITER-1:0] rs_i,
   input  logic [ITER-1:0] rt_i,
   input  logic            hilo_rd_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [ITER-1:0] hi_o,
   output logic [ITER-1:0] lo_o
);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [2*ITER-1:0]   acc, acc_next, prod;
   logic [ITER-1:0]     mag, mq, mq_next, rs_raw;
   logic [ITER-1:0]     rs_mag, rt_mag, fix_hi, fix_lo;
   logic                is_div, neg_q, neg_r, div0;
   logic                rs_neg, rt_neg;

   assign busy_o  = (state != ST_IDLE);
   assign stall_o = busy_o & (start_i | hilo_rd_i);

   assign rs_neg = ~op_i[0] & rs_i[ITER-1];
   assign rt_neg = ~op_i[0] & rt_i[ITER-1];
   assign rs_mag = cond_neg(rs_i, rs_neg);
   assign rt_mag = cond_neg(rt_i, rt_neg);

`ifdef MULDIV_ZERO_SKIP_EN
   logic zero_opnd;
   assign zero_opnd = (rt_i == '0) | (~op_i[1] & (rs_i == '0));
`endif

   muldiv_step u_step (
      .is_div   (is_div),
      .mag      (mag),
      .acc      (acc),
      .mq       (mq),
      .acc_next (acc_next),
      .mq_next  (mq_next)
   );

   // Divide-by-zero returns the dividend exactly as supplied, so it bypasses the sign fix-up.
   always_comb begin
      prod   = neg_q ? (~acc + 1'b1) : acc;
      fix_hi = prod[2*ITER-1:ITER];
      fix_lo = prod[ITER-1:0];
      if (is_div) begin
         if (div0) begin
            fix_hi = rs_raw;
            fix_lo = DIV0_QUOT;
         end else begin
            fix_hi = cond_neg(acc[ITER-1:0], neg_r);
            fix_lo = cond_neg(mq, neg_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         acc    <= '0;
         mag    <= '0;
         mq     <= '0;
         rs_raw <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         hi_o   <= '0;
         lo_o   <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (flush_i) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: if (start_i) begin
                  is_div <= op_i[1];
                  mag    <= op_i[1] ? rt_mag : rs_mag;
                  mq     <= op_i[1] ? rs_mag : rt_mag;
                  neg_q  <= rs_neg ^ rt_neg;
                  neg_r  <= rs_neg;
                  div0   <= op_i[1] & (rt_i == '0);
                  rs_raw <= rs_i;
                  acc    <= '0;
                  cnt    <= '0;
`ifdef MULDIV_ZERO_SKIP_EN
                  state  <= zero_opnd ? ST_FIXUP : ST_CALC;
`else
                  state  <= ST_CALC;
`endif
               end
               ST_CALC: begin
                  acc <= acc_next;
                  mq  <= mq_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(ITER-1)) state <= ST_FIXUP;
               end
               ST_FIXUP: begin
                  hi_o   <= fix_hi;
                  lo_o   <= fix_lo;
                  done_o <= 1'b1;
                  state  <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed vector bench for ex_muldiv_unit

module tb_ex_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, start_i, hilo_rd_i, flush_i;
   logic [1:0]  op_i;
   logic [31:0] rs_i, rt_i;
   logic        busy_o, stall_o, done_o;
   logic [31:0] hi_o, lo_o;

   always #5 clk = ~clk;

   ex_muldiv_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start_i),
      .op_i      (op_i),
      .rs_i      (rs_i),
      .rt_i      (rt_i),
      .hilo_rd_i (hilo_rd_i),
      .flush_i   (flush_i),
      .busy_o    (busy_o),
      .stall_o   (stall_o),
      .done_o    (done_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

`ifdef MULDIV_ZERO_SKIP_EN
   localparam int ZERO_LAT = 2;
`else
   localparam int ZERO_LAT = 34;
`endif

   typedef struct {
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      bit          zero;
   } vec_t;

   vec_t        vecs [13];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] prev_hi = '0;
   logic [31:0] prev_lo = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_lat, input string name);
      int cyc;
      @(negedge clk);
      start_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 1;
      chk({name, "_busy"}, 64'(busy_o), 64'd1);
      chk({name, "_hilo_hold"}, {hi_o, lo_o}, {prev_hi, prev_lo});
      while (done_o !== 1'b1 && cyc < 80) begin
         @(negedge clk);
         cyc++;
      end
      chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
      chk({name, "_hi"}, 64'(hi_o), 64'(exp_hi));
      chk({name, "_lo"}, 64'(lo_o), 64'(exp_lo));
      chk({name, "_idle"}, 64'(busy_o), 64'd0);
      prev_hi = exp_hi;
      prev_lo = exp_lo;
      @(negedge clk);
      chk({name, "_done_pulse"}, 64'(done_o), 64'd0);
   endtask

   initial begin
      int  cyc;
      bit  seen_done;

      vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
      vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0};
      vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
      vecs[5]  = '{MD_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1};
      vecs[6]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
      vecs[7]  = '{MD_MULT,  32'd0,         32'd12345,    32'd0,         32'd0,         1'b1};
      vecs[8]  = '{MD_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[9]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
      vecs[10] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         1'b0};
      vecs[11] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd16,       32'd15,        32'h0FFF_FFFF, 1'b0};
      vecs[12] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0};

      rst_n = 1'b0; start_i = 1'b0; hilo_rd_i = 1'b0; flush_i = 1'b0;
      op_i = 2'b00; rs_i = '0; rt_i = '0;
      repeat (3) @(negedge clk);
      hilo_rd_i = 1'b1;
      #1;
      chk("reset_busy",  64'(busy_o),  64'd0);
      chk("reset_stall", 64'(stall_o), 64'd0);
      chk("reset_done",  64'(done_o),  64'd0);
      chk("reset_hilo",  {hi_o, lo_o}, 64'd0);
      hilo_rd_i = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++)
         run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo,
                vecs[i].zero ? ZERO_LAT : 34, $sformatf("vec%0d", i));

      // MFHI/MFLO stall window plus a second mul/div held off until the first completes
      @(negedge clk);
      start_i = 1'b1; op_i = MD_MULTU; rs_i = 32'd6; rt_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         hilo_rd_i = (c >= 5);
         if (c == 10) begin
            start_i = 1'b1; op_i = MD_MULTU; rs_i = 32'd3; rt_i = 32'd5;
         end
         #1;
         chk($sformatf("stall_c%0d", c), 64'(stall_o), 64'((c >= 5) && (c <= 33)));
         if (c == 34) begin
            chk("stall_done34", 64'(done_o), 64'd1);
            chk("stall_lo42", {hi_o, lo_o}, 64'd42);
         end
         @(negedge clk);
      end
      start_i = 1'b0;
      hilo_rd_i = 1'b0;
      chk("second_accepted", 64'(busy_o), 64'd1);
      cyc = 35;
      while (done_o !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("second_latency", 64'(cyc), 64'd68);
      chk("second_result", {hi_o, lo_o}, 64'd15);
      prev_hi = 32'd0;
      prev_lo = 32'd15;

      // flush mid-divide keeps the preloaded HI/LO
      run_op(MD_MULTU, 32'd2, 32'h8000_0001, 32'd1, 32'd2, 34, "preload");
      start_i = 1'b1; op_i = MD_DIV; rs_i = 32'd100; rt_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      seen_done = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (done_o) seen_done = 1'b1;
         @(negedge clk);
      end
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_idle", 64'(busy_o), 64'd0);
      chk("flush_hilo", {hi_o, lo_o}, {32'd1, 32'd2});
      for (int c = 0; c < 40; c++) begin
         if (done_o) seen_done = 1'b1;
         @(negedge clk);
      end
      chk("flush_no_done", 64'(seen_done), 64'd0);
      chk("flush_hilo_late", {hi_o, lo_o}, {32'd1, 32'd2});

      start_i = 1'b1; flush_i = 1'b1; op_i = MD_DIVU; rs_i = 32'd9; rt_i = 32'd3;
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      chk("flush_start_ignored", 64'(busy_o), 64'd0);

      // reset mid-divide
      start_i = 1'b1; op_i = MD_DIV; rs_i = 32'd100; rt_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      hilo_rd_i = 1'b1;
      #1;
      chk("rst_mid_busy",  64'(busy_o),  64'd0);
      chk("rst_mid_stall", 64'(stall_o), 64'd0);
      chk("rst_mid_done",  64'(done_o),  64'd0);
      chk("rst_mid_hilo",  {hi_o, lo_o}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hilo_rd_i = 1'b0;
      prev_hi = '0;
      prev_lo = '0;

      run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
